// File: rtl/gpr_scoreboard_pkg.sv
// Shared constants for the GPR late-write scoreboard.
package gpr_scoreboard_pkg;

    // Register-file geometry shared with the rest of the core.
    localparam int GPR_ADDR_SPACE = 5;
    localparam int GPR_WIDTH      = 32;

    // Generic single-bit enable levels.
    localparam logic On  = 1'b1;
    localparam logic Off = 1'b0;

    // Scoreboard sizing.
    localparam int SB_NUM_GPR    = 32;
    localparam int SB_CNT_WIDTH  = 32;
    localparam int SB_PCNT_WIDTH = 6;

endpackage : gpr_scoreboard_pkg

// File: rtl/sb_hazard_check.sv
// Combinational RAW/WAW check of the ID instruction against pending late
// writes. A late result being written back this cycle is treated as already
// resolved, because the register file is write-first.
module sb_hazard_check
    import gpr_scoreboard_pkg::*;
#(
    parameter int NUM_GPR = SB_NUM_GPR
) (
    input  logic [NUM_GPR-1:0]        pending,
    input  logic [GPR_ADDR_SPACE-1:0] rs1_addr,
    input  logic                      rs1_re,
    input  logic [GPR_ADDR_SPACE-1:0] rs2_addr,
    input  logic                      rs2_re,
    input  logic [GPR_ADDR_SPACE-1:0] rd_addr,
    input  logic                      rd_we,
    input  logic                      id_valid,
    input  logic                      id_flush,
    input  logic [GPR_ADDR_SPACE-1:0] wb_rd_addr,
    input  logic                      wb_late_we,
    output logic                      hazard_stall
);

    logic [NUM_GPR-1:0] eff;
    logic               raw;
    logic               waw;

    // Effective pending set: mask out the register retiring through WB now.
    always_comb begin
        // NOTE: assigning a default before the loop keeps every bit driven on
        // every path, so no latch can be inferred.
        eff = pending;
        for (int r = 0; r < NUM_GPR; r++) begin
            if (wb_late_we && (wb_rd_addr == GPR_ADDR_SPACE'(r))) begin
                eff[r] = 1'b0;
            end
        end
    end

    assign raw = (rs1_re & eff[rs1_addr]) | (rs2_re & eff[rs2_addr]);
    assign waw = rd_we & eff[rd_addr];

    assign hazard_stall = id_valid & ~id_flush & (raw | waw);

endmodule : sb_hazard_check

// File: rtl/gpr_scoreboard.sv
// Scoreboard of GPRs awaiting a late (load/divider) result. Stalls ID on a
// RAW or WAW conflict with a pending late write and clears entries as those
// writes retire through WB.
module gpr_scoreboard
    import gpr_scoreboard_pkg::*;
#(
    parameter int NUM_GPR   = SB_NUM_GPR,
    parameter int CNT_WIDTH = SB_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [GPR_ADDR_SPACE-1:0] id_rs1_addr,
    input  logic                      id_rs1_re,
    input  logic [GPR_ADDR_SPACE-1:0] id_rs2_addr,
    input  logic                      id_rs2_re,
    input  logic [GPR_ADDR_SPACE-1:0] id_rd_addr,
    input  logic                      id_rd_we,
    input  logic                      id_rd_late,
    input  logic                      id_valid,
    input  logic                      id_flush,
    input  logic [GPR_ADDR_SPACE-1:0] wb_rd_addr,
    input  logic                      wb_late_we,
    output logic                      hazard_stall,
    output logic [SB_PCNT_WIDTH-1:0]  pending_cnt,
    output logic [CNT_WIDTH-1:0]      stall_cycles
);

    // x0 is never tracked, so the state vector starts at bit 1.
    logic [NUM_GPR-1:1]       pending;
    logic [NUM_GPR-1:1]       pending_next;
    logic [NUM_GPR-1:0]       pending_vec;
    logic [SB_PCNT_WIDTH-1:0] cnt_next;
    logic                     issue;

    assign pending_vec = {pending, 1'b0};

    sb_hazard_check #(
        .NUM_GPR (NUM_GPR)
    ) u_hazard (
        .pending      (pending_vec),
        .rs1_addr     (id_rs1_addr),
        .rs1_re       (id_rs1_re),
        .rs2_addr     (id_rs2_addr),
        .rs2_re       (id_rs2_re),
        .rd_addr      (id_rd_addr),
        .rd_we        (id_rd_we),
        .id_valid     (id_valid),
        .id_flush     (id_flush),
        .wb_rd_addr   (wb_rd_addr),
        .wb_late_we   (wb_late_we),
        .hazard_stall (hazard_stall)
    );

    assign issue = id_valid & ~id_flush & ~hazard_stall;

    // Next pending set: a younger late producer setting a bit beats a WB clear
    // of the same bit; then count the resulting pending registers.
    always_comb begin
        pending_next = '0;
        cnt_next     = '0;
        for (int r = 1; r < NUM_GPR; r++) begin
            pending_next[r] =
                (issue & id_rd_we & id_rd_late & (id_rd_addr == GPR_ADDR_SPACE'(r))) |
                (pending[r] & ~(wb_late_we & (wb_rd_addr == GPR_ADDR_SPACE'(r))));
            cnt_next = cnt_next + SB_PCNT_WIDTH'(pending_next[r]);
        end
    end

    // Pending bits and their registered population count.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            // NOTE: the pending bits are control flags, not data storage, so
            // they must be reset; a stale bit would stall ID forever.
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_next;
            pending_cnt <= cnt_next;
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (hazard_stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

endmodule : gpr_scoreboard

// File: tb/tb_gpr_scoreboard.sv
// Self-checking bench for gpr_scoreboard: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_gpr_scoreboard;
    import gpr_scoreboard_pkg::*;

    localparam int AW = GPR_ADDR_SPACE;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
    logic          id_rs1_re, id_rs2_re, id_rd_we, id_rd_late;
    logic          id_valid, id_flush, wb_late_we;

    logic          hazard_stall, sat_hazard_stall;
    logic [5:0]    pending_cnt, sat_pending_cnt;
    logic [31:0]   stall_cycles;
    logic [3:0]    sat_stall_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpr_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs1_re    (id_rs1_re),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs2_re    (id_rs2_re),
        .id_rd_addr   (id_rd_addr),
        .id_rd_we     (id_rd_we),
        .id_rd_late   (id_rd_late),
        .id_valid     (id_valid),
        .id_flush     (id_flush),
        .wb_rd_addr   (wb_rd_addr),
        .wb_late_we   (wb_late_we),
        .hazard_stall (hazard_stall),
        .pending_cnt  (pending_cnt),
        .stall_cycles (stall_cycles)
    );

    // Narrow-counter copy on the same stimulus, to exercise saturation.
    gpr_scoreboard #(.CNT_WIDTH(4)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs1_re    (id_rs1_re),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs2_re    (id_rs2_re),
        .id_rd_addr   (id_rd_addr),
        .id_rd_we     (id_rd_we),
        .id_rd_late   (id_rd_late),
        .id_valid     (id_valid),
        .id_flush     (id_flush),
        .wb_rd_addr   (wb_rd_addr),
        .wb_late_we   (wb_late_we),
        .hazard_stall (sat_hazard_stall),
        .pending_cnt  (sat_pending_cnt),
        .stall_cycles (sat_stall_cycles)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit      m_busy [32];     // register awaiting a late result
    longint  m_stall;         // unbounded stall count, capped when compared
    int      m_stall_sat;
    bit      m_started = 0;

    function automatic bit model_stall();
        bit busy [32];
        busy = m_busy;
        if (wb_late_we) busy[wb_rd_addr] = 0;   // write-first regfile bypass
        if (!id_valid || id_flush) return 0;
        return (id_rs1_re && busy[id_rs1_addr]) ||
               (id_rs2_re && busy[id_rs2_addr]) ||
               (id_rd_we  && busy[id_rd_addr]);
    endfunction

    function automatic int model_count();
        int n = 0;
        foreach (m_busy[i]) n += int'(m_busy[i]);
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_stall     = 0;
            m_stall_sat = 0;
            m_started   = 1;
        end else if (m_started) begin
            bit stall;
            stall = model_stall();
            if (stall) begin
                if (m_stall < 64'hFFFF_FFFF) m_stall++;
                if (m_stall_sat < 15) m_stall_sat++;
            end
            if (wb_late_we && wb_rd_addr != 0) m_busy[wb_rd_addr] = 0;
            if (id_valid && !id_flush && !stall && id_rd_we && id_rd_late && id_rd_addr != 0)
                m_busy[id_rd_addr] = 1;
        end
    end

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (m_started) begin
            check("model_hazard",     {63'd0, hazard_stall},   {63'd0, model_stall()});
            check("model_pcnt",       {58'd0, pending_cnt},    64'(model_count()));
            check("model_stall",      {32'd0, stall_cycles},   64'(m_stall));
            check("model_sat_stall",  {60'd0, sat_stall_cycles}, 64'(m_stall_sat));
            check("model_sat_pcnt",   {58'd0, sat_pending_cnt}, 64'(model_count()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic fl,
                         input logic r1e, input logic [AW-1:0] r1,
                         input logic r2e, input logic [AW-1:0] r2,
                         input logic we, input logic late, input logic [AW-1:0] rd,
                         input logic wbe, input logic [AW-1:0] wb);
        id_valid = v;  id_flush = fl;
        id_rs1_re = r1e; id_rs1_addr = r1;
        id_rs2_re = r2e; id_rs2_addr = r2;
        id_rd_we = we; id_rd_late = late; id_rd_addr = rd;
        wb_late_we = wbe; wb_rd_addr = wb;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_pcnt",  {58'd0, pending_cnt}, 64'd0);
        check("rst_stall", {32'd0, stall_cycles}, 64'd0);
        check("rst_hz",    {63'd0, hazard_stall}, 64'd0);

        // Load-use: late write x5, consumer next cycle, WB three cycles later.
        drive(1, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0);
        #1 check("lu_producer_hz", {63'd0, hazard_stall}, 64'd0);
        tick();
        drive(1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        #1 check("lu_stall1", {63'd0, hazard_stall}, 64'd1);
        check("lu_pcnt1", {58'd0, pending_cnt}, 64'd1);
        tick();
        #1 check("lu_stall2", {63'd0, hazard_stall}, 64'd1);
        tick();
        drive(1, 0, 1, 5, 0, 0, 0, 0, 0, 1, 5);
        #1 check("lu_wb_bypass", {63'd0, hazard_stall}, 64'd0);
        tick();
        idle();
        #1 check("lu_stall_cycles", {32'd0, stall_cycles}, 64'd2);
        check("lu_pcnt_end", {58'd0, pending_cnt}, 64'd0);

        // x0: a late write to x0 never becomes pending.
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        tick();
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        #1 check("x0_hz", {63'd0, hazard_stall}, 64'd0);
        check("x0_pcnt", {58'd0, pending_cnt}, 64'd0);
        tick();

        // WAW on x7: stall until WB, then the new producer re-arms x7.
        drive(1, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0);
        #1 check("waw_stall1", {63'd0, hazard_stall}, 64'd1);
        check("waw_pcnt1", {58'd0, pending_cnt}, 64'd1);
        tick();
        #1 check("waw_stall2", {63'd0, hazard_stall}, 64'd1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 7, 1, 7);
        #1 check("waw_wb_hz", {63'd0, hazard_stall}, 64'd0);
        tick();
        idle();
        #1 check("waw_pcnt_rearm", {58'd0, pending_cnt}, 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        tick();
        idle();
        #1 check("waw_pcnt_end", {58'd0, pending_cnt}, 64'd0);

        // Flush: a squashed late write to x9 sets nothing.
        drive(1, 1, 0, 0, 0, 0, 1, 1, 9, 0, 0);
        #1 check("flush_hz", {63'd0, hazard_stall}, 64'd0);
        tick();
        drive(1, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        #1 check("flush_read_hz", {63'd0, hazard_stall}, 64'd0);
        check("flush_pcnt", {58'd0, pending_cnt}, 64'd0);
        tick();

        // Reset mid-operation with x3 and x4 pending.
        drive(1, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0);
        tick();
        drive(1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        #1 check("mid_pcnt_before", {58'd0, pending_cnt}, 64'd2);
        do_reset();
        #1 check("mid_pcnt_after", {58'd0, pending_cnt}, 64'd0);
        check("mid_stall_after", {32'd0, stall_cycles}, 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        tick();
        drive(1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        #1 check("stray_wb_pcnt", {58'd0, pending_cnt}, 64'd0);
        check("stray_wb_hz", {63'd0, hazard_stall}, 64'd0);
        tick();

        // Saturation: 20 stalled cycles on a 4-bit counter.
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 10, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        #1 check("sat_stall_4b",  {60'd0, sat_stall_cycles}, 64'd15);
        check("sat_stall_32b", {32'd0, stall_cycles}, 64'd20);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10);
        tick();

        // Randomized traffic on a narrow register window to force collisions.
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_flush    = ($urandom_range(0, 7) == 0);
            id_rs1_re   = 1'($urandom);
            id_rs1_addr = AW'($urandom_range(0, 7));
            id_rs2_re   = 1'($urandom);
            id_rs2_addr = AW'($urandom_range(0, 7));
            id_rd_we    = 1'($urandom);
            id_rd_late  = 1'($urandom);
            id_rd_addr  = AW'($urandom_range(0, 7));
            wb_late_we  = ($urandom_range(0, 2) == 0);
            wb_rd_addr  = AW'($urandom_range(0, 7));
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gpr_scoreboard
